var_bw_mul_seq: RTL and testbench

- Clocked, iterative shift-add counterpart of the variable bit-width multiplier.
- Consumes the same operand bundle (para_mode, a, b) through a valid/ready handshake and returns p through a valid/ready handshake.
- Modes: one 16x16 unsigned multiply, or two independent 8x8 unsigned multiplies.
- Serves as the area-optimised multiplier option and as a sequential DUT for the same testbench environment.

---
 rtl/var_bw_mul_seq.sv | 120 ++++++++++++
 tb/tb_var_bw_mul_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/var_bw_mul_seq.sv
// Iterative shift-add multiplier: one 2*LANE_W x 2*LANE_W or two LANE_W x LANE_W unsigned products.
// Optional early termination on an all-zero remaining multiplier: define VAR_BW_MUL_SEQ_EARLY_TERM_EN.
module var_bw_mul_seq #(
    parameter int LANE_W         = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                para_mode,
    input  logic [2*LANE_W-1:0] a,
    input  logic [2*LANE_W-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*LANE_W-1:0] p,
    output logic                busy
);

    localparam int W  = 2 * LANE_W;
    localparam int PW = 4 * LANE_W;
    localparam int K  = BITS_PER_CYCLE;
    localparam int CW = $clog2(W);

    localparam logic [CW-1:0] CNT_FULL = CW'(W / K - 1);
    localparam logic [CW-1:0] CNT_LANE = CW'(LANE_W / K - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(K == 1 || K == 2 || K == 4) || (LANE_W % K != 0)) begin : g_bad_bits_per_cycle
            $error("var_bw_mul_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide LANE_W");
        end
    endgenerate

    logic [1:0]    state;
    logic          mode_q;
    logic [PW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [PW-1:0] pp;
    logic [PW-1:0] mcand_lo;
    logic [PW-1:0] mcand_hi;
    logic [PW-1:0] acc_nxt;
    logic [W-1:0]  mplier_nxt;
    logic          last;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_BUSY);
    assign out_valid = (state == S_DONE);

    // In lane mode the high multiplicand sits in the upper half, so lane sums never overlap.
    always_comb begin
        pp       = '0;
        mcand_lo = {{W{1'b0}}, mcand[W-1:0]};
        mcand_hi = {mcand[PW-1:W], {W{1'b0}}};
        for (int k = 0; k < K; k++) begin
            if (mode_q) begin
                if (mplier[k])          pp = pp + (mcand_lo << k);
                if (mplier[LANE_W + k]) pp = pp + (mcand_hi << k);
            end else if (mplier[k]) begin
                pp = pp + (mcand << k);
            end
        end
        acc_nxt = acc + pp;
        if (mode_q) mplier_nxt = {mplier[W-1:LANE_W] >> K, mplier[LANE_W-1:0] >> K};
        else        mplier_nxt = mplier >> K;
`ifdef VAR_BW_MUL_SEQ_EARLY_TERM_EN
        last = (cnt == '0) || (mplier_nxt == '0);
`else
        last = (cnt == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mode_q <= para_mode;
                        mcand  <= para_mode ?
                                  {{LANE_W{1'b0}}, a[W-1:LANE_W], {LANE_W{1'b0}}, a[LANE_W-1:0]} :
                                  {{W{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= para_mode ? CNT_LANE : CNT_FULL;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << K;
                    mplier <= mplier_nxt;
                    cnt    <= cnt - 1'b1;
                    if (last) begin
                        p     <= acc_nxt;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_var_bw_mul_seq.sv
// Directed bench for var_bw_mul_seq: hand-computed products, latencies, backpressure and reset.
module tb_var_bw_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        para_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

`ifdef VAR_BW_MUL_SEQ_EARLY_TERM_EN
    localparam int E_0302 = 3;
    localparam int E_1234 = 5;
    localparam int E_23   = 2;
    localparam int E_79   = 4;
    localparam int E_ABCD = 1;
`else
    localparam int E_0302 = 8;
    localparam int E_1234 = 16;
    localparam int E_23   = 16;
    localparam int E_79   = 16;
    localparam int E_ABCD = 16;
`endif

    var_bw_mul_seq #(.LANE_W(8), .BITS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .para_mode (para_mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts one bundle, scrambles the operand inputs, then waits (bounded) for out_valid.
    task automatic run_op(input logic m, input logic [15:0] av, input logic [15:0] bv,
                          output int edges, output int low);
        int n = 0;
        para_mode = m;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        para_mode = ~m;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        edges = 0;
        low   = in_ready ? 0 : 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (!in_ready) low++;
        end
    endtask

    initial begin
        int edges;
        int low;
        logic [31:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        para_mode = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_busy",      {31'b0, busy},      32'd0);
        chk("reset_p",         p,                  32'd0);
        rst_n = 1'b1;

        // Full width, worst-case operands.
        run_op(1'b0, 16'hFFFF, 16'hFFFF, edges, low);
        chk("full_ffff_p",     p,     32'hFFFE0001);
        chk("full_ffff_edges", edges, 32'd16);
        @(posedge clk); #1;
        if (!in_ready) low++;
        chk("full_ffff_in_ready_low", low, 32'd17);
        chk("full_ffff_back_idle", {30'b0, in_ready, out_valid}, 32'b10);

        // Lane packing.
        run_op(1'b1, 16'h0302, 16'h0504, edges, low);
        chk("lane_small_p",     p,     32'h000F0008);
        chk("lane_small_edges", edges, E_0302);
        @(posedge clk); #1;
        run_op(1'b1, 16'hFFFF, 16'hFFFF, edges, low);
        chk("lane_ffff_p",     p,     32'hFE01FE01);
        chk("lane_ffff_edges", edges, 32'd8);
        @(posedge clk); #1;

        // Backpressure with a competing bundle offered during DONE.
        out_ready = 1'b0;
        run_op(1'b0, 16'h1234, 16'h0010, edges, low);
        chk("bp_p",     p,     32'h00012340);
        chk("bp_edges", edges, E_1234);
        held      = p;
        in_valid  = 1'b1;
        para_mode = 1'b0;
        a         = 16'h0005;
        b         = 16'h0005;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
            chk("bp_p_held",         p,                  held);
            chk("bp_in_ready_low",   {31'b0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("bp_release_idle", {30'b0, in_ready, out_valid}, 32'b10);
        chk("bp_release_p",    p, 32'h00012340);

        // Reset at the fifth BUSY edge discards the operation.
        para_mode = 1'b0;
        a         = 16'h00FF;
        b         = 16'h00FF;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_busy_low",  {31'b0, busy},      32'd0);
        chk("rst_mid_p",         p,                  32'd0);
        run_op(1'b0, 16'd2, 16'd3, edges, low);
        chk("after_rst_p",     p,     32'd6);
        chk("after_rst_edges", edges, E_23);
        @(posedge clk); #1;

        // Operands are overwritten during BUSY by run_op; result must reflect accepted values.
        run_op(1'b0, 16'd7, 16'd9, edges, low);
        chk("stable_p",     p,     32'h0000003F);
        chk("stable_edges", edges, E_79);
        @(posedge clk); #1;

        run_op(1'b0, 16'hABCD, 16'h0001, edges, low);
        chk("early_p",     p,     32'h0000ABCD);
        chk("early_edges", edges, E_ABCD);
        @(posedge clk); #1;
        chk("final_idle", {30'b0, in_ready, out_valid}, 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
